stream_byte_aligner: RTL
========================

// Module: stream_byte_aligner
// PURPOSE
//  Streaming, packet-aware successor to the combinational alignment network.
//  Takes a valid/ready stream of DATA_WIDTH-bit words, drops the first
//  start_off bytes of each packet and repacks the remaining bytes into dense
//  output words. Carries residual bytes across word boundaries and flushes
//  them at packet end. Per-packet optional byte reversal.
//  Sits between the buffer read port and downstream word consumers.
// PARAMETERS
//  DATA_WIDTH  64                   word width in bits; multiple of 8, >= 16
//  BYTES       DATA_WIDTH/8         bytes per word (derived, do not override)
//  OFF_W       $clog2(BYTES)        width of byte offset (derived)
// PORTS
//  clk        in   1           single clock, all logic on rising edge
//  rst        in   1           synchronous, active-high reset
//  in_data    in   DATA_WIDTH  input word; byte i = in_data[8i+7:8i]
//  in_valid   in   1           input word valid
//  in_ready   out  1           input word accepted when in_valid && in_ready
//  in_sop     in   1           first word of packet
//  in_last    in   1           last word of packet (may coincide with in_sop)
//  start_off  in   OFF_W       leading bytes to drop; sampled only on sop beat
//  last_bytes in   OFF_W+1     valid bytes in last word (1..BYTES); sampled on last
//  reverse    in   1           byte-reverse output words; sampled on sop beat
//  out_data   out  DATA_WIDTH  aligned word; bytes >= out_bytes are zero
//  out_bytes  out  OFF_W+1     valid bytes in out_data (1..BYTES)
//  out_valid  out  1           output word valid
//  out_ready  in   1           downstream accepts when out_valid && out_ready
//  out_last   out  1           last output word of packet
//  pkt_err    out  1           one-cycle pulse on protocol/size error
// BEHAVIOUR
//  - Reset: out_valid, out_last, pkt_err, out_data, out_bytes = 0; residual
//    count rc = 0; state IDLE. Reset mid-packet discards all held bytes.
//  - Output is a single registered stage. in_ready = (state!=FLUSH) &&
//    (!out_valid || out_ready). Held out_* stay stable while out_valid &&
//    !out_ready.
//  - FSM: IDLE -> STREAM on accepted sop without last. STREAM -> IDLE on
//    accepted last, or -> FLUSH if last beat emitted a word and rc>0 remains.
//    FLUSH emits rc bytes with out_last=1 when output stage free -> IDLE.
//  - Accepted beat: n = valid bytes (BYTES, or last_bytes on last) minus
//    start_off on sop. Bytes are appended behind the rc residual bytes.
//    If rc+n >= BYTES: emit BYTES bytes next cycle, rc <= rc+n-BYTES.
//    Else no emit, rc <= rc+n. On last with no word emitted this beat and
//    rc+n > 0: emit rc+n bytes with out_last=1, no FLUSH.
//  - Latency: output word registered 1 cycle after the beat that completes it.
//  - out_last set on the final word of the packet only (FLUSH word, or the
//    last-beat word when no residual remains).
//  - reverse latched per packet: within out_data, byte i <-> byte
//    out_bytes-1-i; zero bytes above out_bytes are unaffected.
//  - Errors (pkt_err pulse, next cycle):
//    (a) sop+last with last_bytes <= start_off -> no output, stay IDLE;
//    (b) accepted beat without sop in IDLE -> beat dropped;
//    (c) sop in STREAM -> residual discarded, no out_last for the old packet,
//        the new packet starts normally.
//  - last_bytes = 0 or > BYTES is undefined (assertion only).
// STRUCTURE
//  - Shared package: BYTES/OFF_W derivation, FSM state encoding
//    (IDLE, STREAM, FLUSH).
//  - One sub-module: byte_pack_shifter, a combinational 2*BYTES-byte funnel.
//    Inputs are residual, new word, rc and start_off; outputs are the packed
//    word and the new residual.
// TESTING (DATA_WIDTH=64; W0=64'h0706050403020100, W1=64'h0F0E0D0C0B0A0908)
//  1 off=0, W0(sop),W1(last,8) -> W0,W1 at 1-cycle latency, bytes=8, last on 2nd
//  2 off=3, W0(sop),W1(last,8) -> 64'h0A09080706050403/8, then FLUSH
//    64'h0000000F0E0D0C0B/5 with last
//  3 off=2, W0 sop+last, last_bytes=6 -> 64'h05040302/4 last; same with
//    reverse=1 -> 64'h02030405/4
//  4 repeat 2 with out_ready low 3 cycles on first output -> in_ready low,
//    out_* stable, no byte lost or duplicated
//  5 off=4 sop+last last_bytes=4 -> no out_valid, pkt_err pulse; beat
//    without sop in IDLE -> pkt_err, dropped
//  6 sop during STREAM -> pkt_err, old residual gone; rst mid-packet ->
//    out_valid=0 next cycle, next packet clean

Source files
------------

// File: rtl/stream_byte_aligner_pkg.sv
// Shared definitions for the packet-aware byte aligner: FSM encoding and
// width derivations from the word width.
package stream_byte_aligner_pkg;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StStream = 2'd1,
      StFlush  = 2'd2
   } state_e;

   function automatic int unsigned bytes_of(input int unsigned dw);
      return dw / 8;
   endfunction

   function automatic int unsigned off_w_of(input int unsigned dw);
      return $clog2(dw / 8);
   endfunction

endpackage

// File: rtl/stream_byte_aligner_byte_pack_shifter.sv
// Combinational 2*BYTES-byte funnel: appends the valid bytes of a new word,
// starting at start_off, behind rc residual bytes.
module stream_byte_aligner_byte_pack_shifter
   import stream_byte_aligner_pkg::*;
#(
   parameter int unsigned DataWidth = 64,
   localparam int unsigned Bytes = bytes_of(DataWidth),
   localparam int unsigned OffW  = off_w_of(DataWidth)
) (
   input  logic [DataWidth-1:0] residual_i,
   input  logic [DataWidth-1:0] word_i,
   input  logic [OffW-1:0]      rc_i,
   input  logic [OffW-1:0]      start_off_i,
   input  logic [OffW:0]        in_bytes_i,
   output logic [DataWidth-1:0] packed_o,
   output logic [DataWidth-1:0] residual_o
);

   logic [DataWidth-1:0]   masked;
   logic [DataWidth-1:0]   aligned;
   logic [2*DataWidth-1:0] merged;

   always_comb begin
      masked = '0;
      // Bytes past the valid count are zeroed so packed words stay clean above out_bytes.
      for (int i = 0; i < int'(Bytes); i++) begin
         if (i < int'(in_bytes_i)) begin
            masked[8*i +: 8] = word_i[8*i +: 8];
         end
      end
      aligned    = masked >> {start_off_i, 3'b000};
      merged     = {{DataWidth{1'b0}}, residual_i} |
                   ({{DataWidth{1'b0}}, aligned} << {rc_i, 3'b000});
      packed_o   = merged[DataWidth-1:0];
      residual_o = merged[2*DataWidth-1:DataWidth];
   end

endmodule

// File: rtl/stream_byte_aligner.sv
// Streaming byte aligner: drops leading bytes of each packet, repacks the rest
// into dense words with a single registered output stage.
module stream_byte_aligner
   import stream_byte_aligner_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 64,
   localparam int unsigned BYTES = bytes_of(DATA_WIDTH),
   localparam int unsigned OFF_W = off_w_of(DATA_WIDTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  in_sop,
   input  logic                  in_last,
   input  logic [OFF_W-1:0]      start_off,
   input  logic [OFF_W:0]        last_bytes,
   input  logic                  reverse,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [OFF_W:0]        out_bytes,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  out_last,
   output logic                  pkt_err
);

   localparam int unsigned CW = OFF_W + 2;
   localparam logic [CW-1:0]  BytesC = CW'(BYTES);
   localparam logic [OFF_W:0] BytesB = (OFF_W + 1)'(BYTES);

   state_e                state_q, state_d;
   logic [OFF_W-1:0]      rc_q, rc_d;
   logic [DATA_WIDTH-1:0] res_q, res_d;
   logic                  rev_q, rev_d;
   logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
   logic [OFF_W:0]        out_bytes_q, out_bytes_d;
   logic                  out_valid_q, out_valid_d;
   logic                  out_last_q, out_last_d;
   logic                  err_q, err_d;

   logic                  accept;
   logic                  bad_sop;
   logic [DATA_WIDTH-1:0] sh_res;
   logic [OFF_W-1:0]      sh_rc;
   logic [OFF_W-1:0]      sh_off;
   logic [OFF_W:0]        sh_bytes;
   logic [DATA_WIDTH-1:0] sh_packed;
   logic [DATA_WIDTH-1:0] sh_high;
   logic [CW-1:0]         total;
   logic                  rev_eff;

   logic                  take;
   logic                  emit;
   logic                  emit_last;
   logic                  emit_rev;
   logic [DATA_WIDTH-1:0] emit_word;
   logic [OFF_W:0]        emit_cnt;

   function automatic logic [DATA_WIDTH-1:0] rev_bytes(input logic [DATA_WIDTH-1:0] w,
                                                       input logic [OFF_W:0]        cnt);
      logic [DATA_WIDTH-1:0] r;
      r = '0;
      for (int i = 0; i < int'(BYTES); i++) begin
         for (int j = 0; j < int'(BYTES); j++) begin
            if ((i < int'(cnt)) && (j == int'(cnt) - 1 - i)) begin
               r[8*i +: 8] = w[8*j +: 8];
            end
         end
      end
      return r;
   endfunction

   assign in_ready = (state_q != StFlush) && (!out_valid_q || out_ready);
   assign accept   = in_valid && in_ready;
   assign bad_sop  = in_sop && in_last && (last_bytes <= {1'b0, start_off});

   // A sop beat always starts from an empty residual, which also discards a broken packet.
   assign sh_res   = in_sop ? '0 : res_q;
   assign sh_rc    = in_sop ? '0 : rc_q;
   assign sh_off   = in_sop ? start_off : '0;
   assign sh_bytes = in_last ? last_bytes : BytesB;
   assign total    = CW'(sh_rc) + CW'(sh_bytes) - CW'(sh_off);
   assign rev_eff  = in_sop ? reverse : rev_q;

   stream_byte_aligner_byte_pack_shifter #(
      .DataWidth(DATA_WIDTH)
   ) u_shifter (
      .residual_i (sh_res),
      .word_i     (in_data),
      .rc_i       (sh_rc),
      .start_off_i(sh_off),
      .in_bytes_i (sh_bytes),
      .packed_o   (sh_packed),
      .residual_o (sh_high)
   );

   always_comb begin
      state_d     = state_q;
      rc_d        = rc_q;
      res_d       = res_q;
      rev_d       = rev_q;
      out_data_d  = out_data_q;
      out_bytes_d = out_bytes_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      err_d       = 1'b0;
      take        = 1'b0;
      emit        = 1'b0;
      emit_last   = 1'b0;
      emit_rev    = 1'b0;
      emit_word   = '0;
      emit_cnt    = '0;

      if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
         out_last_d  = 1'b0;
      end

      unique case (state_q)
         StIdle: begin
            if (accept) begin
               if (!in_sop || bad_sop) begin
                  err_d = 1'b1;
               end else begin
                  take = 1'b1;
               end
            end
         end
         StStream: begin
            if (accept) begin
               if (in_sop) begin
                  err_d = 1'b1;
               end
               if (bad_sop) begin
                  state_d = StIdle;
                  rc_d    = '0;
                  res_d   = '0;
               end else begin
                  take = 1'b1;
               end
            end
         end
         StFlush: begin
            if (!out_valid_q || out_ready) begin
               emit      = 1'b1;
               emit_word = res_q;
               emit_cnt  = {1'b0, rc_q};
               emit_last = 1'b1;
               emit_rev  = rev_q;
               rc_d      = '0;
               res_d     = '0;
               state_d   = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      if (take) begin
         rev_d    = rev_eff;
         emit_rev = rev_eff;
         if (total >= BytesC) begin
            emit      = 1'b1;
            emit_word = sh_packed;
            emit_cnt  = BytesB;
            rc_d      = OFF_W'(total - BytesC);
            res_d     = sh_high;
            if (!in_last) begin
               state_d = StStream;
            end else if (rc_d != '0) begin
               state_d = StFlush;
            end else begin
               emit_last = 1'b1;
               state_d   = StIdle;
            end
         end else if (in_last) begin
            emit      = 1'b1;
            emit_word = sh_packed;
            emit_cnt  = (OFF_W + 1)'(total);
            emit_last = 1'b1;
            rc_d      = '0;
            res_d     = '0;
            state_d   = StIdle;
         end else begin
            rc_d    = OFF_W'(total);
            res_d   = sh_packed;
            state_d = StStream;
         end
      end

      if (emit) begin
         out_valid_d = 1'b1;
         out_last_d  = emit_last;
         out_bytes_d = emit_cnt;
         out_data_d  = emit_rev ? rev_bytes(emit_word, emit_cnt) : emit_word;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         rc_q        <= '0;
         res_q       <= '0;
         rev_q       <= 1'b0;
         out_data_q  <= '0;
         out_bytes_q <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         rc_q        <= rc_d;
         res_q       <= res_d;
         rev_q       <= rev_d;
         out_data_q  <= out_data_d;
         out_bytes_q <= out_bytes_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         err_q       <= err_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_bytes = out_bytes_q;
   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   assign pkt_err   = err_q;

endmodule
